quad_decoder: RTL and testbench

- Upstream front end for each rotary encoder. Takes the raw A/B pins, synchronizes and debounces them, decodes quadrature direction, and emits single-cycle cw/ccw pulses.
- The pulses feed the BCD up/down counter stage directly; one instance is used per encoder.
- Also reports illegal transitions (both phases changing together) for debug.

---
 rtl/quad_decoder.sv | 150 +++++++++++++++
 tb/tb_quad_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module  : quad_decoder
// Brief   : Synchronizes and debounces raw encoder A/B pins, decodes quadrature
//           direction and emits one-cycle cw/ccw step pulses and an err flag.
// Revision: 1.0 - initial release
// ============================================================================
module quad_decoder #(
    parameter int unsigned FILT_CYCLES     = 500,
    parameter int unsigned STEPS_PER_PULSE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic       cw,
    output logic       ccw,
    output logic       err,
    output logic [1:0] ab_filt
);

    localparam logic [15:0]       c_CNT_MAX = 16'(FILT_CYCLES - 1);
    localparam logic signed [3:0] c_STEPS   = 4'(STEPS_PER_PULSE);

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         cand_q;
    logic [15:0]        cnt_q;
    logic [1:0]         ab_filt_q;
    logic [1:0]         old_q;
    logic               evt_q;
    logic signed [3:0]  acc_q, acc_d;
    logic signed [3:0]  w_acc_step;
    logic               cw_q, cw_d;
    logic               ccw_q, ccw_d;
    logic               err_q, err_d;
    logic               w_accept;

    // Next phase value when rotating clockwise (A leads B).
    function automatic logic [1:0] cw_next(input logic [1:0] v);
        logic [1:0] r;
        case (v)
            2'b00:   r = 2'b10;
            2'b10:   r = 2'b11;
            2'b11:   r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // INIT accepts the first stable value even if it matches the reset value.
    assign w_accept = (cnt_q == c_CNT_MAX) && (sync2_q == cand_q) &&
                      ((state_q == S_INIT) || (cand_q != ab_filt_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            cand_q    <= 2'b11;
            cnt_q     <= '0;
            ab_filt_q <= 2'b11;
            old_q     <= 2'b11;
            evt_q     <= 1'b0;
        end else begin
            sync1_q <= {a, b};
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != c_CNT_MAX) begin
                cnt_q <= cnt_q + 16'd1;
            end
            evt_q <= 1'b0;
            if (w_accept) begin
                ab_filt_q <= cand_q;
                old_q     <= ab_filt_q;
                evt_q     <= (state_q == S_TRACK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            acc_q   <= '0;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cw_q    <= cw_d;
            ccw_q   <= ccw_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        w_acc_step = acc_q;
        cw_d       = 1'b0;
        ccw_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_INIT: begin
                if (w_accept) begin
                    state_d = S_TRACK;
                end
            end
            default: begin
                if (evt_q) begin
                    // A reversal restarts the count from the new direction.
                    if (ab_filt_q == cw_next(old_q)) begin
                        w_acc_step = (acc_q < 4'sd0) ? 4'sd1 : acc_q + 4'sd1;
                        if (w_acc_step == c_STEPS) begin
                            cw_d  = 1'b1;
                            acc_d = '0;
                        end else begin
                            acc_d = w_acc_step;
                        end
                    end else if (old_q == cw_next(ab_filt_q)) begin
                        w_acc_step = (acc_q > 4'sd0) ? -4'sd1 : acc_q - 4'sd1;
                        if (w_acc_step == -c_STEPS) begin
                            ccw_d = 1'b1;
                            acc_d = '0;
                        end else begin
                            acc_d = w_acc_step;
                        end
                    end else begin
                        err_d = 1'b1;
                        acc_d = '0;
                    end
                end
            end
        endcase
    end

    assign cw      = cw_q;
    assign ccw     = ccw_q;
    assign err     = err_q;
    assign ab_filt = ab_filt_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// Bench for quad_decoder: two instances (1 and 4 steps per pulse) share the pins
// and are compared every cycle against a model built on the sampled pin history.
module tb_quad_decoder;

    localparam int FILT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b1;
    logic       b   = 1'b1;
    logic       cw1, ccw1, err1, cw4, ccw4, err4;
    logic [1:0] abf1, abf4;
    logic [1:0] cw_v, ccw_v, err_v;

    always #5 clk = ~clk;

    quad_decoder #(.FILT_CYCLES(FILT), .STEPS_PER_PULSE(1)) u_dut1 (
        .clk(clk), .reset(rst), .a(a), .b(b),
        .cw(cw1), .ccw(ccw1), .err(err1), .ab_filt(abf1)
    );

    quad_decoder #(.FILT_CYCLES(FILT), .STEPS_PER_PULSE(4)) u_dut4 (
        .clk(clk), .reset(rst), .a(a), .b(b),
        .cw(cw4), .ccw(ccw4), .err(err4), .ab_filt(abf4)
    );

    assign cw_v  = {cw4, cw1};
    assign ccw_v = {ccw4, ccw1};
    assign err_v = {err4, err1};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int steps_p [2] = '{1, 4};

    // model state
    logic [1:0] hist [$];
    logic [1:0] m_filt = 2'b11;
    logic [1:0] m_old  = 2'b11;
    logic [1:0] m_new  = 2'b11;
    bit         m_init  = 1'b1;
    bit         m_pend  = 1'b0;
    bit         m_valid = 1'b0;
    int         m_acc [2] = '{0, 0};
    bit         e_cw  [2] = '{0, 0};
    bit         e_ccw [2] = '{0, 0};
    bit         e_err [2] = '{0, 0};

    // observed pulse statistics
    int n_cw [2] = '{0, 0};
    int n_ccw[2] = '{0, 0};
    int n_err[2] = '{0, 0};
    int t_ccw[2] = '{0, 0};
    int t_err[2] = '{0, 0};
    int b_cw [2];
    int b_ccw[2];
    int b_err[2];

    logic [1:0] cur = 2'b11;
    int         chg = 0;

    function automatic int pos_of(input logic [1:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (cw_seq[i] == v) r = i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A value is accepted once FILT+1 consecutive synced samples agree; the
    // synced sample seen at edge n is the pin sampled at edge n-2.
    initial forever begin
        @(posedge clk);
        cyc++;
        m_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e_cw[k] = 1'b0; e_ccw[k] = 1'b0; e_err[k] = 1'b0;
        end
        if (rst) begin
            hist.delete();
            repeat (3) hist.push_back(2'b11);
            m_filt = 2'b11;
            m_init = 1'b1;
            m_pend = 1'b0;
            m_acc  = '{0, 0};
        end else begin
            if (m_pend) begin
                int d;
                d = (pos_of(m_new) - pos_of(m_old) + 4) % 4;
                for (int k = 0; k < 2; k++) begin
                    if (d == 2) begin
                        e_err[k] = 1'b1;
                        m_acc[k] = 0;
                    end else if (d == 1) begin
                        if (m_acc[k] < 0) m_acc[k] = 0;
                        m_acc[k]++;
                        if (m_acc[k] == steps_p[k]) begin
                            e_cw[k] = 1'b1;
                            m_acc[k] = 0;
                        end
                    end else begin
                        if (m_acc[k] > 0) m_acc[k] = 0;
                        m_acc[k]--;
                        if (m_acc[k] == -steps_p[k]) begin
                            e_ccw[k] = 1'b1;
                            m_acc[k] = 0;
                        end
                    end
                end
            end
            m_pend = 1'b0;
            hist.push_back({a, b});
            if (hist.size() > FILT + 3) void'(hist.pop_front());
            if (hist.size() == FILT + 3) begin
                bit stable;
                stable = 1'b1;
                for (int i = 0; i <= FILT; i++) if (hist[i] != hist[0]) stable = 1'b0;
                if (stable && (m_init || hist[0] != m_filt)) begin
                    if (!m_init) begin
                        m_pend = 1'b1;
                        m_old  = m_filt;
                        m_new  = hist[0];
                    end
                    m_filt = hist[0];
                    m_init = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("ab_filt_s1", {30'd0, abf1}, {30'd0, m_filt});
            chk("ab_filt_s4", {30'd0, abf4}, {30'd0, m_filt});
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cw_dut%0d", k), {31'd0, cw_v[k]},  {31'd0, e_cw[k]});
                chk($sformatf("ccw_dut%0d", k), {31'd0, ccw_v[k]}, {31'd0, e_ccw[k]});
                chk($sformatf("err_dut%0d", k), {31'd0, err_v[k]}, {31'd0, e_err[k]});
                if (cw_v[k])  n_cw[k]++;
                if (ccw_v[k]) begin n_ccw[k]++; t_ccw[k] = cyc; end
                if (err_v[k]) begin n_err[k]++; t_err[k] = cyc; end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_cw = n_cw; b_ccw = n_ccw; b_err = n_err;
    endtask

    function automatic int pulses_since();
        int s = 0;
        for (int k = 0; k < 2; k++)
            s += (n_cw[k] - b_cw[k]) + (n_ccw[k] - b_ccw[k]) + (n_err[k] - b_err[k]);
        return s;
    endfunction

    task automatic do_reset(input logic [1:0] p);
        rst = 1'b1; {a, b} = p; cur = p;
        tick(3);
        rst = 1'b0;
        tick(12);
    endtask

    task automatic drive(input logic [1:0] p);
        {a, b} = p; cur = p; chg = cyc + 1;
        tick(10);
    endtask

    task automatic step(input bit cw_dir);
        int i;
        i = pos_of(cur);
        drive(cw_seq[cw_dir ? (i + 1) % 4 : (i + 3) % 4]);
    endtask

    initial begin
        snap();
        do_reset(2'b00);
        chk("rst00_abf", {30'd0, abf1}, 32'd0);
        chk("rst00_abf4", {30'd0, abf4}, 32'd0);
        chk("rst00_pulses", pulses_since(), 0);

        snap();
        do_reset(2'b11);
        chk("rst11_abf", {30'd0, abf1}, 32'd3);
        chk("rst11_pulses", pulses_since(), 0);

        snap();
        repeat (4) begin
            step(1'b0);
            chk("ccw_latency", t_ccw[0] - chg, 7);
        end
        chk("ccw_seq_ccw1", n_ccw[0] - b_ccw[0], 4);
        chk("ccw_seq_cw1", n_cw[0] - b_cw[0], 0);
        chk("ccw_seq_ccw4", n_ccw[1] - b_ccw[1], 1);

        snap();
        repeat (6) step(1'b1);
        repeat (5) step(1'b0);
        chk("mix_cw4", n_cw[1] - b_cw[1], 1);
        chk("mix_ccw4", n_ccw[1] - b_ccw[1], 1);
        chk("mix_cw1", n_cw[0] - b_cw[0], 6);
        chk("mix_ccw1", n_ccw[0] - b_ccw[0], 5);
        chk("model_acc4", m_acc[1], -1);

        repeat (3) step(1'b1);
        do_reset(2'b11);
        snap();
        {a, b} = 2'b01;
        tick(3);
        {a, b} = 2'b11;
        tick(15);
        chk("glitch_abf", {30'd0, abf1}, 32'd3);
        chk("glitch_pulses", pulses_since(), 0);
        step(1'b1);
        chk("rstmid_cw1", n_cw[0] - b_cw[0], 1);
        chk("rstmid_cw4", n_cw[1] - b_cw[1], 0);
        chk("model_acc4b", m_acc[1], 1);

        step(1'b0);
        snap();
        drive(2'b00);
        chk("err_latency", t_err[0] - chg, 7);
        chk("illegal_err1", n_err[0] - b_err[0], 1);
        chk("illegal_err4", n_err[1] - b_err[1], 1);
        chk("illegal_dir", (n_cw[0] - b_cw[0]) + (n_ccw[0] - b_ccw[0]), 0);
        snap();
        step(1'b1);
        chk("after_err_cw1", n_cw[0] - b_cw[0], 1);
        chk("after_err_abf", {30'd0, abf1}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
